// File: rtl/picosoc_bus_fabric_pkg.sv
// Shared types and constants for the picorv32 bus fabric.
package picosoc_bus_pkg;

    localparam int          MAX_SLAVES        = 16;
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Width of a slave index; a single-slave fabric still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/picosoc_bus_fabric_if.sv
// picorv32 native port plus the per-slave request/response lines.
// master: CPU and peripheral side; slave: the fabric itself.
interface picosoc_bus_fabric_if #(
    parameter int NUM_SLAVES = 4
);
    logic                    m_valid;
    logic                    m_instr;
    logic [31:0]             m_addr;
    logic [31:0]             m_wdata;
    logic [3:0]              m_wstrb;
    logic                    m_ready;
    logic [31:0]             m_rdata;

    logic [NUM_SLAVES-1:0]   s_valid;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic [NUM_SLAVES-1:0]   s_ready;
    logic [32*NUM_SLAVES-1:0] s_rdata;

    modport master (
        output m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );

    modport slave (
        input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );

endinterface

// File: rtl/picosoc_bus_fabric_addr_decode.sv
// Priority address matcher: slot i hits when (addr & mask_i) == base_i, lowest index wins.
// Purely combinational, no latency and no handshake.
module picosoc_addr_decode #(
    parameter int                        NUM_SLAVES = 4,
    parameter int                        SEL_W      = 2,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FFFF}}
) (
    input  logic [31:0]      i_addr,
    output logic             o_hit,
    output logic [SEL_W-1:0] o_idx
);

    // Scan from the top down so the lowest matching slot is written last.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((i_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                o_hit = 1'b1;
                o_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// N-slave picorv32 interconnect with error termination of unmapped or hung accesses.
// Latency 1 cycle to m_ready (2 with REG_RESP); waits on s_ready up to TIMEOUT_CYCLES.
module picosoc_bus_fabric
    import picosoc_bus_pkg::*;
#(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFF}},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]               ERR_RDATA      = DEFAULT_ERR_RDATA,
    parameter bit                        REG_RESP       = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    picosoc_bus_fabric_if.slave  bus,
    output logic                 irq_buserr,
    output logic [31:0]          err_addr,
    output logic [7:0]           err_count
);

    localparam int SEL_W = sel_width(NUM_SLAVES);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_resp;
    logic [31:0]        r_err_addr;
    logic [7:0]         r_err_count;

    logic               w_hit;
    logic [SEL_W-1:0]   w_idx;
    logic               w_sel_rdy;
    logic [31:0]        w_sel_rdata;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_timeout;
    logic               w_m_ready;
    logic [31:0]        w_m_rdata;
    logic               w_irq;
    logic [NUM_SLAVES-1:0] w_s_valid;
    logic               w_unused_instr;

    picosoc_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .i_addr (bus.m_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_unused_instr = bus.m_instr;
    assign w_sel_rdy      = bus.s_ready[r_sel];
    assign w_sel_rdata    = bus.s_rdata[32*int'(r_sel) +: 32];

    // w_count_inc is the number of WAIT cycles spent including the current one.
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_count_inc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_nxt = r_state;
        w_m_ready   = 1'b0;
        w_m_rdata   = '0;
        w_irq       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.m_valid) begin
                    w_state_nxt = w_hit ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                if (!bus.m_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sel_rdy) begin
                    if (REG_RESP) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_m_ready   = 1'b1;
                        w_m_rdata   = w_sel_rdata;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_RESP: begin
                w_m_ready   = 1'b1;
                w_m_rdata   = r_resp;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_m_ready   = 1'b1;
                w_m_rdata   = ERR_RDATA;
                w_irq       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_count     <= '0;
            r_resp      <= '0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && bus.m_valid && w_hit) begin
                r_sel   <= w_idx;
                r_count <= '0;
            end else if (r_state == ST_WAIT) begin
                r_count <= w_count_inc;
            end
            if (r_state == ST_WAIT && w_sel_rdy) begin
                r_resp <= w_sel_rdata;
            end
            if (r_state == ST_ERR) begin
                r_err_addr <= bus.m_addr;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_s_valid = '0;
        if (r_state == ST_WAIT && bus.m_valid) begin
            w_s_valid[r_sel] = 1'b1;
        end
    end

    // A slave answering in the reset cycle must not complete the aborted transfer.
    assign bus.m_ready = w_m_ready & ~reset;
    assign bus.m_rdata = reset ? 32'h0 : w_m_rdata;
    assign irq_buserr  = w_irq & ~reset;
    assign bus.s_valid = w_s_valid;
    assign bus.s_addr  = bus.m_addr;
    assign bus.s_wdata = bus.m_wdata;
    assign bus.s_wstrb = bus.m_wstrb;
    assign err_addr    = r_err_addr;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Bench for picosoc_bus_fabric: per-cycle vector table plus an error-saturation sequence.
module tb_picosoc_bus_fabric;

    localparam int NS = 4;
    localparam logic [32*NS-1:0] BASE  = {32'h0000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
    localparam logic [32*NS-1:0] MASK  = {32'hFFFF_FF00, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
    localparam logic [32*NS-1:0] RDATA = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'hA0A0_0000};
    localparam logic [31:0] WDATA = 32'hCAFE_F00D;
    localparam logic [31:0] BEEF  = 32'hDEAD_BEEF;
    localparam logic [31:0] UNM   = 32'hF000_0000;
    localparam logic [31:0] D0    = 32'hA0A0_0000;
    localparam logic [31:0] D1    = 32'h1111_1111;
    localparam logic [31:0] D2    = 32'h1234_5678;
    localparam logic [31:0] E1    = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        use_b;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [3:0]  s_ready;

    logic        irq_a, irq_b;
    logic [31:0] eaddr_a, eaddr_b;
    logic [7:0]  ecnt_a, ecnt_b;

    picosoc_bus_fabric_if #(.NUM_SLAVES(NS)) bus_a ();
    picosoc_bus_fabric_if #(.NUM_SLAVES(NS)) bus_b ();

    assign bus_a.m_valid = m_valid & ~use_b;
    assign bus_a.m_instr = 1'b0;
    assign bus_a.m_addr  = m_addr;
    assign bus_a.m_wdata = WDATA;
    assign bus_a.m_wstrb = m_wstrb;
    assign bus_a.s_ready = s_ready;
    assign bus_a.s_rdata = RDATA;

    assign bus_b.m_valid = m_valid & use_b;
    assign bus_b.m_instr = 1'b0;
    assign bus_b.m_addr  = m_addr;
    assign bus_b.m_wdata = WDATA;
    assign bus_b.m_wstrb = m_wstrb;
    assign bus_b.s_ready = s_ready;
    assign bus_b.s_rdata = RDATA;

    picosoc_bus_fabric #(
        .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
        .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF), .REG_RESP(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .irq_buserr(irq_a), .err_addr(eaddr_a), .err_count(ecnt_a)
    );

    picosoc_bus_fabric #(
        .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
        .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF), .REG_RESP(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .irq_buserr(irq_b), .err_addr(eaddr_b), .err_count(ecnt_b)
    );

    always #5 clk = ~clk;

    logic        o_rdy, o_irq;
    logic [31:0] o_rdata, o_eaddr, o_saddr, o_swdata;
    logic [3:0]  o_svld, o_swstrb;
    logic [7:0]  o_ecnt;

    assign o_rdy    = use_b ? bus_b.m_ready : bus_a.m_ready;
    assign o_rdata  = use_b ? bus_b.m_rdata : bus_a.m_rdata;
    assign o_svld   = use_b ? bus_b.s_valid : bus_a.s_valid;
    assign o_saddr  = use_b ? bus_b.s_addr  : bus_a.s_addr;
    assign o_swdata = use_b ? bus_b.s_wdata : bus_a.s_wdata;
    assign o_swstrb = use_b ? bus_b.s_wstrb : bus_a.s_wstrb;
    assign o_irq    = use_b ? irq_b   : irq_a;
    assign o_eaddr  = use_b ? eaddr_b : eaddr_a;
    assign o_ecnt   = use_b ? ecnt_b  : ecnt_a;

    typedef struct {
        logic        rst;
        logic        b;
        logic        vld;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [3:0]  srdy;
        logic        rdy;
        logic [31:0] rdata;
        logic [3:0]  svld;
        logic        irq;
        logic [7:0]  ecnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic rst, input logic b, input logic vld,
                                input logic [31:0] addr, input logic [3:0] wstrb, input logic [3:0] srdy,
                                input logic rdy, input logic [31:0] rdata, input logic [3:0] svld,
                                input logic irq, input logic [7:0] ecnt, input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst;  v.b = b;         v.vld = vld;   v.addr = addr;
        v.wstrb = wstrb; v.srdy = srdy; v.rdy = rdy;  v.rdata = rdata;
        v.svld = svld; v.irq = irq;    v.ecnt = ecnt; v.eaddr = eaddr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int irq_seen;
        int rdy_seen;
        irq_seen = 0;
        rdy_seen = 0;
        reset = 1'b1; use_b = 1'b0; m_valid = 1'b0;
        m_addr = '0; m_wstrb = '0; s_ready = '0;

        // rst b vld addr wstrb srdy | rdy rdata svld irq ecnt eaddr
        add(1, 0, 0, 32'h0,         4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        // read hit slot 2, slave answers on the second WAIT cycle
        add(0, 0, 1, 32'h0200_0008, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        add(0, 0, 1, 32'h0200_0008, 4'h0, 4'h0,    0, 0,  4'b0100, 0, 0, 0);
        add(0, 0, 1, 32'h0200_0008, 4'h0, 4'b0100, 1, D2, 4'b0100, 0, 0, 0);
        add(0, 0, 0, 32'h0200_0008, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        // overlapping windows: slot 0 wins, slot 3 ready ignored
        add(0, 0, 1, 32'h0000_0010, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        add(0, 0, 1, 32'h0000_0010, 4'h0, 4'b1000, 0, 0,  4'b0001, 0, 0, 0);
        add(0, 0, 1, 32'h0000_0010, 4'h0, 4'b1001, 1, D0, 4'b0001, 0, 0, 0);
        // back-to-back: new request in the IDLE gap, slave answers on first WAIT cycle
        add(0, 0, 1, 32'h0100_0004, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        add(0, 0, 1, 32'h0100_0004, 4'h0, 4'b0010, 1, D1, 4'b0010, 0, 0, 0);
        add(0, 0, 0, 32'h0100_0004, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        // unmapped write
        add(0, 0, 1, UNM,           4'hF, 4'h0,    0, 0,    4'h0,  0, 0, 0);
        add(0, 0, 1, UNM,           4'hF, 4'h0,    1, BEEF, 4'h0,  1, 0, 0);
        add(0, 0, 0, UNM,           4'h0, 4'h0,    0, 0,    4'h0,  0, 1, UNM);
        // m_valid withdrawn during WAIT: silent return to IDLE
        add(0, 0, 1, 32'h0200_0000, 4'h0, 4'h0,    0, 0,  4'h0,    0, 1, UNM);
        add(0, 0, 1, 32'h0200_0000, 4'h0, 4'h0,    0, 0,  4'b0100, 0, 1, UNM);
        add(0, 0, 0, 32'h0200_0000, 4'h0, 4'h0,    0, 0,  4'h0,    0, 1, UNM);
        add(0, 0, 0, 32'h0200_0000, 4'h0, 4'b0100, 0, 0,  4'h0,    0, 1, UNM);
        // timeout: 8 WAIT cycles, then the error response
        add(0, 0, 1, E1,            4'h0, 4'h0,    0, 0,  4'h0,    0, 1, UNM);
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, E1,        4'h0, 4'h0,    0, 0,  4'b0010, 0, 1, UNM);
        add(0, 0, 1, E1,            4'h0, 4'h0,    1, BEEF, 4'h0,  1, 1, UNM);
        add(0, 0, 0, E1,            4'h0, 4'h0,    0, 0,  4'h0,    0, 2, E1);
        // slave ready on the would-be timeout cycle wins
        add(0, 0, 1, 32'h0200_0004, 4'h0, 4'h0,    0, 0,  4'h0,    0, 2, E1);
        for (int i = 0; i < 7; i++)
            add(0, 0, 1, 32'h0200_0004, 4'h0, 4'h0, 0, 0, 4'b0100, 0, 2, E1);
        add(0, 0, 1, 32'h0200_0004, 4'h0, 4'b0100, 1, D2, 4'b0100, 0, 2, E1);
        add(0, 0, 0, 32'h0200_0004, 4'h0, 4'h0,    0, 0,  4'h0,    0, 2, E1);
        // registered response instance: m_ready one cycle later
        add(0, 1, 1, 32'h0200_0008, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        add(0, 1, 1, 32'h0200_0008, 4'h0, 4'h0,    0, 0,  4'b0100, 0, 0, 0);
        add(0, 1, 1, 32'h0200_0008, 4'h0, 4'b0100, 0, 0,  4'b0100, 0, 0, 0);
        add(0, 1, 1, 32'h0200_0008, 4'h0, 4'h0,    1, D2, 4'h0,    0, 0, 0);
        add(0, 1, 0, 32'h0200_0008, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        // reset during WAIT aborts the transfer and clears the error state
        add(0, 0, 1, 32'h0200_0000, 4'h0, 4'h0,    0, 0,  4'h0,    0, 2, E1);
        add(0, 0, 1, 32'h0200_0000, 4'h0, 4'h0,    0, 0,  4'b0100, 0, 2, E1);
        add(1, 0, 1, 32'h0200_0000, 4'h0, 4'b0100, 0, 0,  4'b0100, 0, 2, E1);
        add(0, 0, 1, 32'h0200_0000, 4'h0, 4'b0100, 0, 0,  4'h0,    0, 0, 0);
        add(0, 0, 0, 32'h0200_0000, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);
        add(0, 0, 0, 32'h0200_0000, 4'h0, 4'h0,    0, 0,  4'h0,    0, 0, 0);

        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset   = vecs[i].rst;
            use_b   = vecs[i].b;
            m_valid = vecs[i].vld;
            m_addr  = vecs[i].addr;
            m_wstrb = vecs[i].wstrb;
            s_ready = vecs[i].srdy;
            #1;
            check("m_ready",    i, 64'(o_rdy),   64'(vecs[i].rdy));
            check("m_rdata",    i, 64'(o_rdata), 64'(vecs[i].rdata));
            check("s_valid",    i, 64'(o_svld),  64'(vecs[i].svld));
            check("irq_buserr", i, 64'(o_irq),   64'(vecs[i].irq));
            check("err_count",  i, 64'(o_ecnt),  64'(vecs[i].ecnt));
            check("err_addr",   i, 64'(o_eaddr), 64'(vecs[i].eaddr));
            check("s_addr_wstrb", i, 64'({o_saddr, o_swstrb}), 64'({vecs[i].addr, vecs[i].wstrb}));
            check("s_wdata",    i, 64'(o_swdata), 64'(WDATA));
        end

        // 300 back-to-back unmapped accesses: counter saturates, last address kept
        use_b   = 1'b0;
        m_wstrb = 4'hF;
        s_ready = 4'h0;
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                m_valid = 1'b1;
                m_addr  = UNM + 32'(i * 4);
                #1;
                if (irq_a) irq_seen++;
                if (bus_a.m_ready && bus_a.m_rdata == BEEF) rdy_seen++;
            end
        end
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        check("sat_err_count", 0, 64'(ecnt_a),  64'd255);
        check("sat_err_addr",  0, 64'(eaddr_a), 64'h0000_0000_F000_04AC);
        check("sat_irq_pulses", 0, 64'(irq_seen), 64'd300);
        check("sat_err_resps", 0, 64'(rdy_seen), 64'd300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
